dac_write: RTL

Transmit-side counterpart of the on-board ADC readout: accepts two's complement samples over a ready/valid stream, buffers them in a small FIFO, and drives one registered word per clock to a parallel single-ended DAC. Data is re-encoded and optionally inverted for the RF path. A priming state machine keeps the DAC at the zero-level code until enough samples are buffered, and detects and counts underruns. Sits between the DSP/AXIS sample source and the DAC pins, in the DAC clock domain.

---
 rtl/dac_write.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/dac_write.sv
// dac_write: ready/valid two's complement sample FIFO feeding a registered parallel DAC word,
// with priming, underrun detection and an optional underflow counter (DAC_WRITE_UNDERFLOW_CNT_EN).
module dac_write #(
  parameter int INT_DAC_DATA_WIDTH       = 14,
  parameter int INT_ODATA_ENC_OFFSETBIN  = 1,
  parameter int INT_DAC_DATA_IS_INVERTED = 0,
  parameter int INT_FIFO_DEPTH           = 4,
  parameter int INT_PRIME_LEVEL          = 2,
  parameter int INT_UNDERFLOW_CNT_WIDTH  = 16
) (
  input  logic                                     in_clk,
  input  logic                                     in_rst_n,
  input  logic                                     in_enable,
  input  logic [INT_DAC_DATA_WIDTH-1:0]            in_data,
  input  logic                                     in_valid,
  output logic                                     out_ready,
  output logic [INT_DAC_DATA_WIDTH-1:0]            out_dac_data,
  output logic                                     out_streaming,
  output logic                                     out_underflow,
  output logic [INT_UNDERFLOW_CNT_WIDTH-1:0]       out_underflow_cnt,
  input  logic                                     in_underflow_clr,
  output logic [$clog2(INT_FIFO_DEPTH+1)-1:0]      out_fifo_level
);

  localparam int W  = INT_DAC_DATA_WIDTH;
  localparam int CW = $clog2(INT_FIFO_DEPTH + 1);
  localparam int PW = $clog2(INT_FIFO_DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(INT_FIFO_DEPTH);
  localparam logic [CW-1:0] PRIME_C = CW'(INT_PRIME_LEVEL);

  function automatic logic [W-1:0] conv(input logic [W-1:0] x);
    logic [W-1:0] y;
    y = x;
    if (INT_ODATA_ENC_OFFSETBIN != 0) y[W-1] = ~y[W-1];
    if (INT_DAC_DATA_IS_INVERTED != 0) y = ~y;
    return y;
  endfunction

  localparam logic [W-1:0] IDLE_WORD = conv({W{1'b0}});

  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_STREAM} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [W-1:0]    dac_q, dac_d;
  logic            uf_q, uf_d;
  logic [W-1:0]    mem_q [INT_FIFO_DEPTH];
  logic            ready, push, pop, flush, wr_en;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    dac_d    = IDLE_WORD;
    uf_d     = 1'b0;
    pop      = 1'b0;
    flush    = 1'b0;
    // ready depends only on state and start-of-cycle occupancy, never on in_valid
    ready    = (state_q != S_IDLE) && (count_q < DEPTH_C);
    push     = in_valid && ready;

    case (state_q)
      S_IDLE: begin
        flush = 1'b1;
        if (in_enable) state_d = S_PRIME;
      end
      S_PRIME: begin
        if (!in_enable) begin
          flush   = 1'b1;
          state_d = S_IDLE;
        end else if (count_q >= PRIME_C) begin
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (!in_enable) begin
          flush   = 1'b1;
          state_d = S_IDLE;
        end else if (count_q != '0) begin
          pop   = 1'b1;
          dac_d = conv(mem_q[rd_ptr_q]);
        end else begin
          uf_d    = 1'b1;
          state_d = S_PRIME;
        end
      end
      default: state_d = S_IDLE;
    endcase

    wr_en = push && !flush;
    if (flush) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      dac_q    <= IDLE_WORD;
      uf_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      dac_q    <= dac_d;
      uf_q     <= uf_d;
    end
  end

  // storage needs no reset: occupancy and pointers define which entries are live
  always_ff @(posedge in_clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= in_data;
  end

`ifdef DAC_WRITE_UNDERFLOW_CNT_EN
  logic [INT_UNDERFLOW_CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (in_underflow_clr)          cnt_d = '0;
    else if (uf_d && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) cnt_q <= '0;
    else           cnt_q <= cnt_d;
  end

  assign out_underflow_cnt = cnt_q;
`else
  logic unused_clr;
  assign unused_clr        = in_underflow_clr;
  assign out_underflow_cnt = '0;
`endif

  assign out_ready      = ready;
  assign out_dac_data   = dac_q;
  assign out_streaming  = (state_q == S_STREAM);
  assign out_underflow  = uf_q;
  assign out_fifo_level = count_q;

endmodule
